// File: rtl/palette_arbiter_if.sv
// Request/response and palette-ROM signals shared between the arbiter and its clients.
// slave is the arbiter's view; master is the client/ROM side.
interface palette_arbiter_if;
    logic       bg_req;
    logic [3:0] bg_idx;
    logic       bg_gnt;
    logic       sp_req;
    logic [3:0] sp_idx;
    logic       sp_gnt;
    logic       bg_vld;
    logic [5:0] bg_color;
    logic       sp_vld;
    logic [5:0] sp_color;
    logic [4:0] rom_addr;
    logic [7:0] rom_dout;

    modport slave (
        input  bg_req, bg_idx, sp_req, sp_idx, rom_dout,
        output bg_gnt, sp_gnt, bg_vld, bg_color, sp_vld, sp_color, rom_addr
    );

    modport master (
        output bg_req, bg_idx, sp_req, sp_idx, rom_dout,
        input  bg_gnt, sp_gnt, bg_vld, bg_color, sp_vld, sp_color, rom_addr
    );
endinterface

// File: rtl/palette_arbiter.sv
// Two-client palette lookup: background and sprite share one synchronous ROM port,
// color-0 entries come from a cached backdrop register; both paths have 2-cycle latency.
module palette_arbiter #(
    parameter bit BACKDROP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload,
    palette_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {INIT_RD, INIT_CAP, RUN} state_t;

    state_t     state;
    state_t     state_next;
    logic       run;
    logic       ptr_bg_last;
    logic [5:0] backdrop;

    logic       bg_bd, sp_bd;
    logic       bg_rom, sp_rom;
    logic       bg_win, sp_win;
    logic       bg_gnt_c, sp_gnt_c;
    logic [4:0] rom_addr_c;

    logic       bg_p1, bg_p1_bd, sp_p1, sp_p1_bd;
    logic       bg_vld_q, sp_vld_q;
    logic [5:0] bg_color_q, sp_color_q;
    logic       rom_dout_unused;

    assign rom_dout_unused = ^bus.rom_dout[7:6];

    assign bg_bd  = BACKDROP_EN && (bus.bg_idx[1:0] == 2'b00);
    assign sp_bd  = BACKDROP_EN && (bus.sp_idx[1:0] == 2'b00);
    assign bg_rom = bus.bg_req && !bg_bd;
    assign sp_rom = bus.sp_req && !sp_bd;
    // On a ROM tie the requester that did not win the previous tie takes the port.
    assign bg_win = bg_rom && (!sp_rom || !ptr_bg_last);
    assign sp_win = sp_rom && (!bg_rom || ptr_bg_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_RD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run        = 1'b0;
        bg_gnt_c   = 1'b0;
        sp_gnt_c   = 1'b0;
        rom_addr_c = '0;
        case (state)
            INIT_RD:  state_next = INIT_CAP;
            INIT_CAP: state_next = RUN;
            RUN: begin
                run      = 1'b1;
                bg_gnt_c = (bus.bg_req && bg_bd) || bg_win;
                sp_gnt_c = (bus.sp_req && sp_bd) || sp_win;
                if (bg_win) begin
                    rom_addr_c = {1'b0, bus.bg_idx};
                end else if (sp_win) begin
                    rom_addr_c = {1'b1, bus.sp_idx};
                end
                if (reload) begin
                    state_next = INIT_RD;
                end
            end
            default:  state_next = INIT_RD;
        endcase
    end

    // Stage 1 tracks the ROM read in flight; stage 2 picks ROM data or the backdrop,
    // which keeps both paths at equal latency so per-client ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_bg_last <= 1'b1;
            backdrop    <= '0;
            bg_p1       <= 1'b0;
            bg_p1_bd    <= 1'b0;
            sp_p1       <= 1'b0;
            sp_p1_bd    <= 1'b0;
            bg_vld_q    <= 1'b0;
            sp_vld_q    <= 1'b0;
            bg_color_q  <= '0;
            sp_color_q  <= '0;
        end else begin
            bg_p1    <= bg_gnt_c;
            bg_p1_bd <= bg_bd;
            sp_p1    <= sp_gnt_c;
            sp_p1_bd <= sp_bd;
            bg_vld_q <= bg_p1;
            sp_vld_q <= sp_p1;
            if (bg_p1) begin
                bg_color_q <= bg_p1_bd ? backdrop : bus.rom_dout[5:0];
            end
            if (sp_p1) begin
                sp_color_q <= sp_p1_bd ? backdrop : bus.rom_dout[5:0];
            end
            if (run && bg_rom && sp_rom) begin
                ptr_bg_last <= bg_win;
            end
            if (state == INIT_CAP) begin
                backdrop <= bus.rom_dout[5:0];
            end
        end
    end

    assign bus.bg_gnt   = bg_gnt_c;
    assign bus.sp_gnt   = sp_gnt_c;
    assign bus.rom_addr = rom_addr_c;
    assign bus.bg_vld   = bg_vld_q;
    assign bus.sp_vld   = sp_vld_q;
    assign bus.bg_color = bg_color_q;
    assign bus.sp_color = sp_color_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Bench for palette_arbiter: grant/address vector table plus a latency-tracking
// scoreboard of expected colors for each client.
module tb_palette_arbiter;

    logic        clk;
    logic        rst_n;
    logic        reload;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    logic [7:0]  rom [32];
    logic [5:0]  backdrop_model;

    typedef struct {
        int unsigned due;
        logic [5:0]  color;
    } exp_t;
    exp_t bg_q[$];
    exp_t sp_q[$];
    int unsigned bg_vld_cnt;
    int unsigned sp_vld_cnt;
    logic        bg_exp_vld;
    logic        sp_exp_vld;

    typedef struct {
        logic       bg_req;
        logic [3:0] bg_idx;
        logic       sp_req;
        logic [3:0] sp_idx;
        logic       exp_bg;
        logic       exp_sp;
        logic [4:0] exp_addr;
    } vec_t;
    vec_t vecs[13];

    palette_arbiter_if bus ();

    palette_arbiter #(.BACKDROP_EN(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (reload),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] exp_color(input logic is_sp, input logic [3:0] idx);
        logic [7:0] word;
        if (idx[1:0] == 2'b00) return backdrop_model;
        word = rom[{is_sp, idx}];
        return word[5:0];
    endfunction

    // Scoreboard: push at acceptance, expect vld exactly two cycles later.
    always @(negedge clk) begin
        bg_exp_vld = (bg_q.size() != 0) && (bg_q[0].due == cyc);
        if (bg_exp_vld || bus.bg_vld) begin
            check("bg_vld", {31'd0, bus.bg_vld}, {31'd0, bg_exp_vld});
            if (bg_exp_vld) begin
                if (bus.bg_vld) check("bg_color", {26'd0, bus.bg_color}, {26'd0, bg_q[0].color});
                void'(bg_q.pop_front());
            end
        end
        sp_exp_vld = (sp_q.size() != 0) && (sp_q[0].due == cyc);
        if (sp_exp_vld || bus.sp_vld) begin
            check("sp_vld", {31'd0, bus.sp_vld}, {31'd0, sp_exp_vld});
            if (sp_exp_vld) begin
                if (bus.sp_vld) check("sp_color", {26'd0, bus.sp_color}, {26'd0, sp_q[0].color});
                void'(sp_q.pop_front());
            end
        end
        if (bus.bg_vld) bg_vld_cnt++;
        if (bus.sp_vld) sp_vld_cnt++;
        if (bus.bg_req && bus.bg_gnt) bg_q.push_back('{due: cyc + 2, color: exp_color(1'b0, bus.bg_idx)});
        if (bus.sp_req && bus.sp_gnt) sp_q.push_back('{due: cyc + 2, color: exp_color(1'b1, bus.sp_idx)});
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) next_cycle();
        check("bg_queue_drained", bg_q.size(), 0);
        check("sp_queue_drained", sp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bg_gnt"}, {31'd0, bus.bg_gnt}, 0);
        check({tag, "_sp_gnt"}, {31'd0, bus.sp_gnt}, 0);
        check({tag, "_bg_vld"}, {31'd0, bus.bg_vld}, 0);
        check({tag, "_sp_vld"}, {31'd0, bus.sp_vld}, 0);
        check({tag, "_bg_color"}, {26'd0, bus.bg_color}, 0);
        check({tag, "_sp_color"}, {26'd0, bus.sp_color}, 0);
        check({tag, "_rom_addr"}, {27'd0, bus.rom_addr}, 0);
    endtask

    task automatic set_req(input logic bq, input logic [3:0] bi, input logic sq, input logic [3:0] si);
        bus.bg_req = bq;
        bus.bg_idx = bi;
        bus.sp_req = sq;
        bus.sp_idx = si;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        int unsigned rel;
        bit          found;
        bit          exp_sp_win;
        int unsigned bg_base;
        int unsigned sp_base;

        n_checks = 0;
        n_pass   = 0;
        bg_vld_cnt = 0;
        sp_vld_cnt = 0;
        cyc = 0;
        for (int unsigned a = 0; a < 32; a++) begin
            rom[a] = {2'b10, 6'(a * 7 + 5)};
        end
        rom[5'h00] = 8'h0F;
        rom[5'h07] = 8'h27;
        rom[5'h0B] = 8'hE1;
        rom[5'h17] = 8'h33;
        rom[5'h1B] = 8'h21;
        backdrop_model = 6'h0F;

        vecs[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'h00};
        vecs[1]  = '{1'b1, 4'h5, 1'b0, 4'h0, 1'b1, 1'b0, 5'h05};
        vecs[2]  = '{1'b0, 4'h0, 1'b1, 4'h6, 1'b0, 1'b1, 5'h16};
        vecs[3]  = '{1'b1, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 5'h00};
        vecs[4]  = '{1'b1, 4'h7, 1'b1, 4'h7, 1'b0, 1'b1, 5'h17};
        vecs[5]  = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b0, 5'h07};
        vecs[6]  = '{1'b1, 4'h9, 1'b1, 4'h3, 1'b1, 1'b0, 5'h09};
        vecs[7]  = '{1'b1, 4'hB, 1'b1, 4'h3, 1'b0, 1'b1, 5'h13};
        vecs[8]  = '{1'b1, 4'hB, 1'b1, 4'h4, 1'b1, 1'b1, 5'h0B};
        vecs[9]  = '{1'b1, 4'h0, 1'b1, 4'hC, 1'b1, 1'b1, 5'h00};
        vecs[10] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 5'h01};
        vecs[11] = '{1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b1, 5'h12};
        vecs[12] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'h00};

        // Reset, then release with bg holding a ROM request at idx 7.
        rst_n  = 1'b0;
        reload = 1'b0;
        set_req(1'b1, 4'h7, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        next_cycle();
        rst_n = 1'b1;
        rel   = cyc;
        found = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cyc == rel) check("init_rd_rom_addr", {27'd0, bus.rom_addr}, 0);
            if (bus.bg_gnt) begin
                found = 1'b1;
                check("first_gnt_cycle", cyc - rel, 2);
                break;
            end
        end
        if (!found) check("first_gnt_timeout", 0, 1);
        next_cycle();
        set_req(1'b0, 4'h0, 1'b0, 4'h0);
        drain();

        // Grant and address table.
        for (int unsigned i = 0; i < 13; i++) begin
            set_req(vecs[i].bg_req, vecs[i].bg_idx, vecs[i].sp_req, vecs[i].sp_idx);
            @(negedge clk);
            check($sformatf("vec%0d_bg_gnt", i), {31'd0, bus.bg_gnt}, {31'd0, vecs[i].exp_bg});
            check($sformatf("vec%0d_sp_gnt", i), {31'd0, bus.sp_gnt}, {31'd0, vecs[i].exp_sp});
            check($sformatf("vec%0d_rom_addr", i), {27'd0, bus.rom_addr}, {27'd0, vecs[i].exp_addr});
            next_cycle();
        end
        drain();

        // Continuous ROM tie: alternate grants, one response per cycle overall.
        bg_base = bg_vld_cnt;
        sp_base = sp_vld_cnt;
        exp_sp_win = 1'b1;
        set_req(1'b1, 4'h7, 1'b1, 4'hB);
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            check("tie_bg_gnt", {31'd0, bus.bg_gnt}, {31'd0, !exp_sp_win});
            check("tie_sp_gnt", {31'd0, bus.sp_gnt}, {31'd0, exp_sp_win});
            exp_sp_win = !exp_sp_win;
            next_cycle();
        end
        set_req(1'b0, 4'h0, 1'b0, 4'h0);
        drain();
        check("tie_bg_vld_count", bg_vld_cnt - bg_base, 4);
        check("tie_sp_vld_count", sp_vld_cnt - sp_base, 4);

        // Backdrop + ROM back-to-back: each client gets one response per cycle.
        bg_base = bg_vld_cnt;
        sp_base = sp_vld_cnt;
        set_req(1'b1, 4'h8, 1'b1, 4'hB);
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stream_both_gnt", {30'd0, bus.bg_gnt, bus.sp_gnt}, 3);
            next_cycle();
        end
        set_req(1'b0, 4'h0, 1'b0, 4'h0);
        drain();
        check("stream_bg_vld_count", bg_vld_cnt - bg_base, 8);
        check("stream_sp_vld_count", sp_vld_cnt - sp_base, 8);

        // Reload with requests in flight; new backdrop appears only after re-init.
        rom[5'h00] = 8'hEA;
        set_req(1'b1, 4'h7, 1'b1, 4'h8);
        reload = 1'b1;
        @(negedge clk);
        check("reload_accept", {30'd0, bus.bg_gnt, bus.sp_gnt}, 3);
        next_cycle();
        reload = 1'b1;
        set_req(1'b1, 4'h5, 1'b1, 4'h4);
        backdrop_model = 6'h2A;
        @(negedge clk);
        check("init_rd_gnt", {30'd0, bus.bg_gnt, bus.sp_gnt}, 0);
        check("reload_rom_addr", {27'd0, bus.rom_addr}, 0);
        next_cycle();
        reload = 1'b0;
        @(negedge clk);
        check("init_cap_gnt", {30'd0, bus.bg_gnt, bus.sp_gnt}, 0);
        next_cycle();
        @(negedge clk);
        check("run_after_reload_gnt", {30'd0, bus.bg_gnt, bus.sp_gnt}, 3);
        check("run_after_reload_addr", {27'd0, bus.rom_addr}, 5'h05);
        next_cycle();
        set_req(1'b0, 4'h0, 1'b0, 4'h0);
        drain();

        // Reset the cycle after acceptance: responses are discarded.
        set_req(1'b1, 4'h7, 1'b1, 4'h4);
        @(negedge clk);
        check("pre_reset_accept", {30'd0, bus.bg_gnt, bus.sp_gnt}, 3);
        next_cycle();
        rst_n = 1'b0;
        bg_q.delete();
        sp_q.delete();
        set_req(1'b0, 4'h0, 1'b0, 4'h0);
        bg_base = bg_vld_cnt;
        sp_base = sp_vld_cnt;
        @(negedge clk);
        check_reset_outputs("midreset");
        next_cycle();
        @(negedge clk);
        check_reset_outputs("midreset2");
        next_cycle();
        check("midreset_no_vld", (bg_vld_cnt - bg_base) + (sp_vld_cnt - sp_base), 0);
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        set_req(1'b0, 4'h0, 1'b1, 4'h8);
        @(negedge clk);
        check("post_reset_sp_gnt", {31'd0, bus.sp_gnt}, 1);
        next_cycle();
        set_req(1'b0, 4'h0, 1'b0, 4'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
